// File: rtl/fifo_pack_pkg.sv
// Shared definitions for the byte-lane packer: pointer sizing, mask constants,
// parameter legality and the flush-pending state encoding.
package fifo_pack_pkg;

  localparam int unsigned MAX_LANES = 64;

  typedef enum logic {
    FL_IDLE,
    FL_PEND
  } flush_state_e;

  function automatic int unsigned lane_ptr_w(input int unsigned lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

  function automatic logic [MAX_LANES-1:0] lane_mask_ones(input int unsigned lanes);
    logic [MAX_LANES-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_LANES; i++) begin
      if (i < lanes) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic bit params_ok(input int unsigned lanes, input int unsigned data_w);
    return (lanes >= 2) && (lanes <= MAX_LANES) && (data_w >= 1);
  endfunction

endpackage

// File: rtl/fifo_pack_if.sv
// Ingress byte handshake plus FIFO write port of the packer.
interface fifo_pack_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LANES  = 4
) ();

  logic [DATA_W-1:0]       data_in;
  logic                    load_data;
  logic                    flush;
  logic                    in_ready;
  logic                    fifo_full;
  logic [DATA_W*LANES-1:0] fifo_wdata;
  logic [LANES-1:0]        fifo_wmask;
  logic                    write_en;

  modport master (
    input  data_in, load_data, flush, fifo_full,
    output in_ready, fifo_wdata, fifo_wmask, write_en
  );

  modport slave (
    output data_in, load_data, flush, fifo_full,
    input  in_ready, fifo_wdata, fifo_wmask, write_en
  );

endinterface

// File: rtl/fifo_pack_outreg.sv
// Output holding register toward the FIFO: write strobe, free flag and the
// modulo written-word counter.
module fifo_pack_outreg #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned LANES  = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_full,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic [LANES-1:0]  load_mask,
  output logic [WORD_W-1:0] out_data,
  output logic [LANES-1:0]  out_mask,
  output logic              write_en,
  output logic              out_free,
  output logic [CNT_W-1:0]  word_count
);

  logic out_valid;

  assign write_en = out_valid & ~fifo_full;
  assign out_free = ~out_valid | ~fifo_full;

  // A reload in the drain cycle keeps out_valid high with the new word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_mask  <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      out_data  <= load_data;
      out_mask  <= load_mask;
      out_valid <= 1'b1;
    end else if (write_en) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_count <= '0;
    end else if (write_en) begin
      word_count <= word_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fifo_pack_ctrl.sv
// Byte-lane packer: assembles LANES input lanes into a word, handles partial
// flush and overflow reporting, and hands words to the output register.
module fifo_pack_ctrl
  import fifo_pack_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LANES  = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  fifo_pack_if.master      bus,
  input  logic             err_clr,
  output logic [CNT_W-1:0] word_count,
  output logic             overflow_err
);

  localparam int unsigned        PTR_W     = lane_ptr_w(LANES);
  localparam logic [PTR_W-1:0]   LAST_LANE = PTR_W'(LANES - 1);
  localparam logic [LANES-1:0]   MASK_ONES = LANES'(lane_mask_ones(LANES));

  if (!params_ok(LANES, DATA_W)) begin : g_param_check
    $error("fifo_pack_ctrl: LANES must be 2..64 and DATA_W at least 1");
  end

  logic [PTR_W-1:0]                   lane_ptr;
  logic [LANES-1:0][DATA_W-1:0]       asm_data;
  logic [LANES-1:0]                   asm_mask;
  logic [LANES-1:0][DATA_W-1:0]       word_nxt;
  logic [LANES-1:0]                   mask_nxt;
  logic [LANES-1:0]                   xfer_mask;
  flush_state_e                       fl_state;
  flush_state_e                       fl_state_nxt;
  logic                               out_free;
  logic                               lane_is_last;
  logic                               accept;
  logic                               last_acc;
  logic                               flush_req;
  logic                               flush_go;
  logic                               xfer;
  logic                               drop;

  assign lane_is_last = (lane_ptr == LAST_LANE);
  assign bus.in_ready = (fl_state == FL_IDLE) & (~lane_is_last | out_free);
  assign accept       = bus.load_data & bus.in_ready;
  assign drop         = bus.load_data & ~bus.in_ready;
  assign last_acc     = accept & lane_is_last;
  assign flush_req    = bus.flush | (fl_state == FL_PEND);

  // A flush that coincides with the last-lane byte is just a full-word
  // transfer; an empty assembly with no incoming byte makes flush a no-op.
  assign flush_go  = flush_req & ~last_acc & ((lane_ptr != '0) | accept);
  assign xfer      = last_acc | (flush_go & out_free);
  assign xfer_mask = last_acc ? MASK_ONES : mask_nxt;

  always_comb begin
    word_nxt = asm_data;
    mask_nxt = asm_mask;
    if (accept) begin
      word_nxt[lane_ptr] = bus.data_in;
      mask_nxt[lane_ptr] = 1'b1;
    end
  end

  always_comb begin
    fl_state_nxt = fl_state;
    if (flush_go & ~out_free) begin
      fl_state_nxt = FL_PEND;
    end else if (flush_req | xfer) begin
      fl_state_nxt = FL_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fl_state <= FL_IDLE;
    end else begin
      fl_state <= fl_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_ptr <= '0;
      asm_data <= '0;
      asm_mask <= '0;
    end else if (xfer) begin
      lane_ptr <= '0;
      asm_data <= '0;
      asm_mask <= '0;
    end else if (accept) begin
      lane_ptr <= lane_ptr + PTR_W'(1);
      asm_data <= word_nxt;
      asm_mask <= mask_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_err <= 1'b0;
    end else if (drop) begin
      overflow_err <= 1'b1;
    end else if (err_clr) begin
      overflow_err <= 1'b0;
    end
  end

  fifo_pack_outreg #(
    .WORD_W (DATA_W * LANES),
    .LANES  (LANES),
    .CNT_W  (CNT_W)
  ) u_outreg (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_full  (bus.fifo_full),
    .load       (xfer),
    .load_data  (word_nxt),
    .load_mask  (xfer_mask),
    .out_data   (bus.fifo_wdata),
    .out_mask   (bus.fifo_wmask),
    .write_en   (bus.write_en),
    .out_free   (out_free),
    .word_count (word_count)
  );

endmodule

// File: tb/tb_fifo_pack_ctrl.sv
// Scoreboard bench for fifo_pack_ctrl: a queue-based packer model predicts
// words, acceptance, count and error flag; a monitor checks every FIFO write.
module tb_fifo_pack_ctrl;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned LANES  = 4;
  localparam int unsigned CNT_W  = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             err_clr;
  logic [CNT_W-1:0] word_count;
  logic             overflow_err;

  always #5 clk = ~clk;

  fifo_pack_if #(.DATA_W(DATA_W), .LANES(LANES)) bus ();

  fifo_pack_ctrl #(
    .DATA_W (DATA_W),
    .LANES  (LANES),
    .CNT_W  (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .err_clr      (err_clr),
    .word_count   (word_count),
    .overflow_err (overflow_err)
  );

  typedef struct {
    logic [31:0] data;
    logic [3:0]  mask;
  } word_t;

  word_t        exp_q[$];
  int unsigned  n_checks = 0;
  int unsigned  n_errors = 0;

  // Reference model: bytes waiting in the current word, one held output word
  logic [7:0]   m_bytes[$];
  bit           m_held;
  bit           m_pend;
  bit           m_err;
  int unsigned  m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void emit_word();
    word_t w;
    w.data = '0;
    w.mask = '0;
    foreach (m_bytes[i]) begin
      w.data = w.data | (32'(m_bytes[i]) << (8 * i));
      w.mask[i] = 1'b1;
    end
    exp_q.push_back(w);
    m_bytes.delete();
    m_held = 1'b1;
  endfunction

  function automatic void model_reset();
    m_bytes.delete();
    exp_q.delete();
    m_held = 1'b0;
    m_pend = 1'b0;
    m_err  = 1'b0;
    m_cnt  = 0;
  endfunction

  // One clock of stimulus; entered and left at posedge+1.
  task automatic step(input bit ld, input logic [7:0] d, input bit fl,
                      input bit full, input bit clr);
    bit free_now, rdy, wr;
    bus.load_data = ld;
    bus.data_in   = d;
    bus.flush     = fl;
    bus.fifo_full = full;
    err_clr       = clr;
    #1;
    free_now = !m_held || !full;
    rdy      = !m_pend && ((m_bytes.size() != LANES - 1) || free_now);
    wr       = m_held && !full;
    chk("in_ready", 64'(bus.in_ready), 64'(rdy));
    if (m_held && exp_q.size() > 0) begin
      chk("held_wdata", 64'(bus.fifo_wdata), 64'(exp_q[0].data));
      chk("held_wmask", 64'(bus.fifo_wmask), 64'(exp_q[0].mask));
    end
    if (wr) begin
      m_held = 1'b0;
      m_cnt  = (m_cnt + 1) % (1 << CNT_W);
    end
    if (ld && !rdy) m_err = 1'b1;
    else if (clr)   m_err = 1'b0;
    if (ld && rdy) m_bytes.push_back(d);
    if (m_bytes.size() == LANES) begin
      emit_word();
      m_pend = 1'b0;
    end else if (fl || m_pend) begin
      if (m_bytes.size() == 0) m_pend = 1'b0;
      else if (free_now) begin
        emit_word();
        m_pend = 1'b0;
      end else m_pend = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("word_count", 64'(word_count), 64'(m_cnt));
    chk("overflow_err", 64'(overflow_err), 64'(m_err));
  endtask

  task automatic do_reset();
    bus.load_data = 1'b0;
    bus.flush     = 1'b0;
    bus.fifo_full = 1'b0;
    bus.data_in   = '0;
    err_clr       = 1'b0;
    rst_n         = 1'b0;
    #2;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_wdata", 64'(bus.fifo_wdata), 64'd0);
    chk("rst_wmask", 64'(bus.fifo_wmask), 64'd0);
    chk("rst_write_en", 64'(bus.write_en), 64'd0);
    chk("rst_word_count", 64'(word_count), 64'd0);
    chk("rst_overflow_err", 64'(overflow_err), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.write_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_write", 64'd1, 64'd0);
      end else begin
        word_t w;
        w = exp_q.pop_front();
        chk("fifo_wdata", 64'(bus.fifo_wdata), 64'(w.data));
        chk("fifo_wmask", 64'(bus.fifo_wmask), 64'(w.mask));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    model_reset();
    #1;
    do_reset();

    // Full word on consecutive cycles
    step(1, 8'h11, 0, 0, 0);
    step(1, 8'h22, 0, 0, 0);
    step(1, 8'h33, 0, 0, 0);
    step(1, 8'h44, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);

    // Partial flush, then the next byte starts at lane 0
    step(1, 8'hAA, 0, 0, 0);
    step(1, 8'hBB, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    step(1, 8'hCC, 0, 0, 0);
    step(1, 8'hDD, 0, 0, 0);
    step(1, 8'hEE, 0, 0, 0);
    step(1, 8'hFF, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);

    // Held word under backpressure, fourth extra byte dropped
    step(1, 8'h01, 0, 0, 0);
    step(1, 8'h02, 0, 0, 0);
    step(1, 8'h03, 0, 0, 0);
    step(1, 8'h04, 0, 1, 0);
    step(1, 8'h05, 0, 1, 0);
    step(1, 8'h06, 0, 1, 0);
    step(1, 8'h07, 0, 1, 0);
    step(1, 8'h08, 0, 1, 0);
    step(0, 8'h00, 0, 1, 0);
    step(0, 8'h00, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 0, 0);

    // Flush against a held, full output; err_clr loses to a drop
    step(1, 8'h10, 0, 0, 0);
    step(1, 8'h20, 0, 0, 0);
    step(1, 8'h30, 0, 0, 0);
    step(1, 8'h40, 0, 1, 0);
    step(1, 8'h50, 0, 1, 0);
    step(0, 8'h00, 1, 1, 0);
    step(1, 8'h60, 0, 1, 1);
    step(0, 8'h00, 0, 1, 1);
    step(0, 8'h00, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);

    // Flush together with the last-lane byte, and with an empty assembly
    step(1, 8'h71, 0, 0, 0);
    step(1, 8'h72, 0, 0, 0);
    step(1, 8'h73, 0, 0, 0);
    step(1, 8'h74, 1, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    step(1, 8'h81, 1, 0, 0);
    step(0, 8'h00, 0, 0, 0);

    // Reset after two bytes discards them
    step(1, 8'h91, 0, 0, 0);
    step(1, 8'h92, 0, 0, 0);
    do_reset();
    step(1, 8'hA1, 0, 0, 0);
    step(1, 8'hA2, 0, 0, 0);
    step(1, 8'hA3, 0, 0, 0);
    step(1, 8'hA4, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);

    // Randomised traffic with varying backpressure and one mid-run reset
    for (int i = 0; i < 3000; i++) begin
      int unsigned full_pct;
      full_pct = (i < 1000) ? 10 : ((i < 2000) ? 60 : 30);
      if (i == 1500) do_reset();
      step($urandom_range(0, 99) < 70,
           8'($urandom),
           $urandom_range(0, 99) < 10,
           $urandom_range(0, 99) < full_pct,
           $urandom_range(0, 99) < 5);
    end

    for (int i = 0; i < 8; i++) step(0, 8'h00, 0, 0, 0);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
